// File: rtl/lcv_mul_acc_pipe.sv
// Pipelined signed multiply-accumulate with valid/ready handshake, persistent accumulator and overflow flag.
// Optional build macro LCV_MUL_ACC_PIPE_SAT_EN: saturate results on overflow instead of wrapping.
module lcv_mul_acc_pipe #(
    parameter int unsigned A_WIDTH   = 16,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH = 48,
    parameter int unsigned LATENCY   = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inp_valid,
    output logic                        inp_ready,
    input  logic signed [A_WIDTH-1:0]   inp_a,
    input  logic signed [B_WIDTH-1:0]   inp_b,
    input  logic signed [ACC_WIDTH-1:0] inp_c,
    input  logic [1:0]                  inp_op,
    output logic                        outp_valid,
    input  logic                        outp_ready,
    output logic signed [ACC_WIDTH-1:0] outp_data,
    output logic                        outp_overflow
);

    localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int unsigned W_WIDTH = ACC_WIDTH + 2;
    localparam int unsigned N_MID   = (LATENCY > 2) ? LATENCY - 2 : 0;

    localparam logic [1:0] OP_MUL_ADD = 2'd0;
    localparam logic [1:0] OP_MAC     = 2'd1;
    localparam logic [1:0] OP_MSU     = 2'd2;

    if (ACC_WIDTH < P_WIDTH) begin : g_chk_acc
        $error("lcv_mul_acc_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
    if (LATENCY < 2) begin : g_chk_lat
        $error("lcv_mul_acc_pipe: LATENCY must be >= 2");
    end

    typedef struct packed {
        logic                 valid;
        logic [1:0]           op;
        logic [ACC_WIDTH-1:0] c;
        logic [P_WIDTH-1:0]   prod;
    } mid_t;

    logic adv;

    logic                        s1_valid_q;
    logic [1:0]                  s1_op_q;
    logic signed [A_WIDTH-1:0]   s1_a_q;
    logic signed [B_WIDTH-1:0]   s1_b_q;
    logic signed [ACC_WIDTH-1:0] s1_c_q;
    logic signed [P_WIDTH-1:0]   s1_prod;
    mid_t                        s1_out;
    mid_t                        fin;

    logic                        out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]        out_data_q,  out_data_d;
    logic                        out_ovf_q,   out_ovf_d;
    logic signed [ACC_WIDTH-1:0] acc_q,       acc_d;

    logic signed [W_WIDTH-1:0]   prod_w;
    logic signed [W_WIDTH-1:0]   c_w;
    logic signed [W_WIDTH-1:0]   acc_w;
    logic signed [W_WIDTH-1:0]   wide;
    logic                        res_ovf;
    logic [ACC_WIDTH-1:0]        res_data;

    // A single advance strobe stalls every stage together.
    assign adv       = !out_valid_q || outp_ready;
    assign inp_ready = adv;

    // Stage 1: operand capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_c_q     <= '0;
        end else if (adv) begin
            s1_valid_q <= inp_valid;
            s1_op_q    <= inp_op;
            s1_a_q     <= inp_a;
            s1_b_q     <= inp_b;
            s1_c_q     <= inp_c;
        end
    end

    assign s1_prod = P_WIDTH'(s1_a_q) * P_WIDTH'(s1_b_q);

    always_comb begin
        s1_out       = '0;
        s1_out.valid = s1_valid_q;
        s1_out.op    = s1_op_q;
        s1_out.c     = s1_c_q;
        s1_out.prod  = s1_prod;
    end

    // Product stages; absent when LATENCY is 2.
    if (N_MID == 0) begin : g_no_mid
        assign fin = s1_out;
    end else begin : g_mid
        mid_t mid_q [N_MID];

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < int'(N_MID); i++) begin
                    mid_q[i] <= '0;
                end
            end else if (adv) begin
                mid_q[0] <= s1_out;
                for (int i = 1; i < int'(N_MID); i++) begin
                    mid_q[i] <= mid_q[i-1];
                end
            end
        end

        assign fin = mid_q[N_MID-1];
    end

    // Final stage: two guard bits expose any overflow of the signed accumulator range.
    always_comb begin
        prod_w = W_WIDTH'($signed(fin.prod));
        c_w    = W_WIDTH'($signed(fin.c));
        acc_w  = W_WIDTH'(acc_q);
        case (fin.op)
            OP_MAC:  wide = acc_w + prod_w;
            OP_MSU:  wide = acc_w - prod_w;
            default: wide = prod_w + c_w;
        endcase
        res_ovf = !((&wide[W_WIDTH-1:ACC_WIDTH-1]) || !(|wide[W_WIDTH-1:ACC_WIDTH-1]));
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
        if (res_ovf) begin
            res_data = wide[W_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            res_data = wide[ACC_WIDTH-1:0];
        end
`else
        res_data = wide[ACC_WIDTH-1:0];
`endif
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        acc_d       = acc_q;
        if (adv) begin
            out_valid_d = fin.valid;
            if (fin.valid) begin
                out_data_d = res_data;
                out_ovf_d  = res_ovf;
                if (fin.op != OP_MUL_ADD) begin
                    acc_d = res_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            acc_q       <= acc_d;
        end
    end

    assign outp_valid    = out_valid_q;
    assign outp_data     = out_data_q;
    assign outp_overflow = out_ovf_q;

endmodule

// File: doc/lcv_mul_acc_pipe.md
Name: lcv_mul_acc_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit for DSP inference. Successor to the fixed-width single-stage mul-acc blocks.
- Adds configurable operand and accumulator widths, configurable pipeline depth, a valid/ready handshake with backpressure, a persistent accumulator with per-op mode select, and overflow reporting.
- Sits between operand producers (filter, dot-product sequencers) and result consumers.

Parameters:
- A_WIDTH, 16, signed multiplicand width.
- B_WIDTH, 16, signed multiplier width.
- ACC_WIDTH, 48, signed accumulator/result width. Must be >= A_WIDTH+B_WIDTH; elaboration-time error otherwise.
- LATENCY, 3, cycles from accepted input to outp_valid with no stalls. Must be >= 2; elaboration-time error otherwise.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- inp_valid  in  1  operand beat valid.
- inp_ready  out  1  unit can accept a beat this cycle.
- inp_a  in  A_WIDTH  signed multiplicand.
- inp_b  in  B_WIDTH  signed multiplier.
- inp_c  in  ACC_WIDTH  signed addend, used by MUL_ADD and LOAD.
- inp_op  in  2  0=MUL_ADD (a*b+c), 1=MAC (acc+a*b), 2=MSU (acc-a*b), 3=LOAD (acc=a*b+c).
- outp_valid  out  1  result valid.
- outp_ready  in  1  consumer accepts the result.
- outp_data  out  ACC_WIDTH  signed result.
- outp_overflow  out  1  true result did not fit in ACC_WIDTH.

Behaviour:
- Reset (rst=0 at posedge): all stage valids 0, accumulator 0, outp_data 0, outp_valid 0, outp_overflow 0. In-flight beats are discarded. Reset has priority over every other event.
- Global advance: adv = !outp_valid || outp_ready.
  - inp_ready = adv (combinational); rst=0 does not gate it.
  - A beat is accepted when inp_valid && inp_ready.
  - When adv=0 every stage holds, including operands, op, valids and outputs.
- Pipeline:
  - Stage 1 registers a, b, c, op and valid.
  - Stages 2..LATENCY-1 carry the sign-extended product (A_WIDTH+B_WIDTH bits) plus c, op and valid.
  - The final stage computes the result, updates the accumulator and drives outp_data, outp_overflow and outp_valid.
  - With LATENCY=2 the product is formed between stage 1 and the final stage.
- Final-stage arithmetic:
  - Evaluated at ACC_WIDTH+2 bits.
  - The product is sign-extended to ACC_WIDTH. The result r is truncated to ACC_WIDTH.
  - overflow = (ACC_WIDTH+2-bit value is outside the signed ACC_WIDTH range).
- Accumulator:
  - MAC, MSU and LOAD write r into the accumulator. MUL_ADD leaves it unchanged.
  - Every op drives outp_data=r.
  - The accumulator is read in the final stage, so back-to-back MACs on consecutive cycles chain correctly without hazard.
- Output register: outp_valid stays high and outp_data/outp_overflow stay stable until outp_ready. No bubbles are inserted when outp_ready is held high.
- Throughput: one beat per cycle while outp_ready=1.
- Simultaneous accept at the input and drain at the output in the same cycle is legal and loses no data.
- Beats are never reordered, dropped or duplicated.

Optional Feature:
- Macro: LCV_MUL_ACC_PIPE_SAT_EN.
- Defined:
  - On overflow, r clamps to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) according to the sign of the wide result.
  - The clamped value goes to both outp_data and the accumulator.
  - outp_overflow is still asserted.
- Undefined: r wraps (two's-complement truncation) and outp_overflow is asserted.
- The overflow flag behaviour is identical in both builds; only the data value differs.

Test Plan:
- Latency/MUL_ADD: defaults, outp_ready=1. Send a=3, b=-4, c=100, op=0 at cycle 0 -> outp_valid exactly 3 cycles later with outp_data=88 and overflow=0; accumulator stays 0.
- MAC chain:
  - Send LOAD a=0,b=0,c=5, then MAC beats (2,3), (-1,7), (4,4) back-to-back.
  - Expected outputs, in order: 5, 11, 4, 20.
  - Then MSU (5,4) -> 0.
- Backpressure:
  - Hold outp_ready=0 for 6 cycles while 5 MAC beats of (1,1) are offered.
  - inp_ready must drop once the first result reaches the output register; outp_data must hold stable.
  - On release, results 1,2,3,4,5 emerge in order with no loss or duplication.
- Overflow: ACC_WIDTH=32, LOAD c=0x7FFFFFF0 then MAC (4,5).
  - Default build: outp_data=0x80000004 with overflow=1.
  - With LCV_MUL_ACC_PIPE_SAT_EN: outp_data=0x7FFFFFFF with overflow=1, and a following MAC (0,0) returns 0x7FFFFFFF.
- Reset mid-operation: issue 3 MAC beats, assert rst=0 for 1 cycle while 2 beats are in flight.
  - Next cycle: outp_valid=0, outp_data=0.
  - A subsequent MAC (2,2) returns 4, proving the accumulator was cleared.
- Extremes: LATENCY=2, A_WIDTH=B_WIDTH=8. MUL_ADD a=-128, b=-128, c=0 -> 16384, outp_valid 2 cycles after accept.
